// File: rtl/arch_bus_pkg.sv
// Shared bus definitions for the cache-bus arbiter and its neighbours.
//   cbus_req_t  : one master's request bundle (valid/addr/wdata/wstrobe/burst/len)
//   cbus_resp_t : response bundle steered back to a master (ready/last/rdata)
//   arb_state_t : arbiter FSM state encoding
package arch_bus_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  wstrobe;
        logic [1:0]  burst;
        logic [7:0]  len;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [63:0] rdata;
    } cbus_resp_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_RELEASE = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: returns the first asserted request found
// scanning ptr_i, ptr_i+1, ... wrapping modulo N (explicit wrap, so any N works).
//   req_i    : request vector
//   ptr_i    : index with highest priority this round (must be < N)
//   onehot_o : one-hot winner (zero when nothing requested)
//   idx_o    : winner index (zero when nothing requested)
//   found_o  : at least one request present
module rr_priority_picker #(
    parameter int N     = 2,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     onehot_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             found_o
);
    localparam logic [IDX_W:0] N_EXT = (IDX_W+1)'(N);
    localparam logic [N-1:0]   ONE   = {{(N-1){1'b0}}, 1'b1};

    logic [IDX_W:0] cand;

    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        cand    = '0;
        // Scan from farthest to nearest so the candidate closest to ptr_i wins.
        for (int k = N-1; k >= 0; k--) begin
            cand = {1'b0, ptr_i} + (IDX_W+1)'(k);
            if (cand >= N_EXT) cand = cand - N_EXT;
            if (req_i[cand[IDX_W-1:0]]) begin
                found_o = 1'b1;
                idx_o   = cand[IDX_W-1:0];
            end
        end
        onehot_o = found_o ? (ONE << idx_o) : '0;
    end

endmodule

// File: rtl/cbus_arbiter.sv
// Round-robin N:1 arbiter in front of the BRAM memory wrapper. One master is
// granted at a time and owns the slave side for its whole burst; after the
// last beat s_valid drops for one RELEASE cycle so the wrapper resets its
// delay counter, then the next grant is arbitrated from IDLE.
//   clk, reset          : clock, asynchronous active-high reset
//   m_valid..m_len      : per-master request fields
//   m_rdata             : read data broadcast to all masters
//   m_ready, m_last     : per-master handshake, only the granted bit can be 1
//   s_valid..s_len      : granted request towards the wrapper (zero unless BUSY)
//   s_rdata/ready/last  : wrapper response
module cbus_arbiter #(
    parameter  int NUM_MASTERS = 2,
    localparam int IDX_W       = $clog2(NUM_MASTERS)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_MASTERS-1:0]      m_valid,
    input  logic [NUM_MASTERS-1:0][63:0] m_addr,
    input  logic [NUM_MASTERS-1:0][63:0] m_wdata,
    input  logic [NUM_MASTERS-1:0][7:0] m_wstrobe,
    input  logic [NUM_MASTERS-1:0][1:0] m_burst,
    input  logic [NUM_MASTERS-1:0][7:0] m_len,
    output logic [63:0]                 m_rdata,
    output logic [NUM_MASTERS-1:0]      m_ready,
    output logic [NUM_MASTERS-1:0]      m_last,
    output logic                        s_valid,
    output logic [63:0]                 s_addr,
    output logic [63:0]                 s_wdata,
    output logic [7:0]                  s_wstrobe,
    output logic [1:0]                  s_burst,
    output logic [7:0]                  s_len,
    input  logic [63:0]                 s_rdata,
    input  logic                        s_ready,
    input  logic                        s_last
);
    import arch_bus_pkg::*;

    arb_state_t             state_q, state_d;
    logic [IDX_W-1:0]       grant_q, grant_d;
    logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [NUM_MASTERS-1:0] gnt_oh_q, gnt_oh_d;

    logic [NUM_MASTERS-1:0] pick_oh;
    logic [IDX_W-1:0]       pick_idx;
    logic                   pick_found;

    cbus_req_t  gnt_req;
    cbus_resp_t slv_resp;

    rr_priority_picker #(
        .N     (NUM_MASTERS),
        .IDX_W (IDX_W)
    ) u_picker (
        .req_i    (m_valid),
        .ptr_i    (rr_ptr_q),
        .onehot_o (pick_oh),
        .idx_o    (pick_idx),
        .found_o  (pick_found)
    );

    // Granted master's request, muxed on the registered grant.
    always_comb begin
        gnt_req.valid   = m_valid[grant_q];
        gnt_req.addr    = m_addr[grant_q];
        gnt_req.wdata   = m_wdata[grant_q];
        gnt_req.wstrobe = m_wstrobe[grant_q];
        gnt_req.burst   = m_burst[grant_q];
        gnt_req.len     = m_len[grant_q];
        slv_resp.ready  = s_ready;
        slv_resp.last   = s_last;
        slv_resp.rdata  = s_rdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            gnt_oh_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            gnt_oh_q <= gnt_oh_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        gnt_oh_d = gnt_oh_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    grant_d  = pick_idx;
                    gnt_oh_d = pick_oh;
                    state_d  = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // A completed burst wins over a same-cycle valid drop.
                if (slv_resp.ready && slv_resp.last) begin
                    state_d  = ST_RELEASE;
                    rr_ptr_d = (grant_q == IDX_W'(NUM_MASTERS-1)) ? '0 : grant_q + IDX_W'(1);
                end else if (!gnt_req.valid) begin
                    // Master abandoned its burst: abort, keep the pointer.
                    state_d = ST_IDLE;
                end
            end
            ST_RELEASE: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        s_valid   = 1'b0;
        s_addr    = '0;
        s_wdata   = '0;
        s_wstrobe = '0;
        s_burst   = '0;
        s_len     = '0;
        m_ready   = '0;
        m_last    = '0;
        m_rdata   = slv_resp.rdata;
        if (state_q == ST_BUSY) begin
            s_valid   = 1'b1;
            s_addr    = gnt_req.addr;
            s_wdata   = gnt_req.wdata;
            s_wstrobe = gnt_req.wstrobe;
            s_burst   = gnt_req.burst;
            s_len     = gnt_req.len;
            m_ready   = gnt_oh_q & {NUM_MASTERS{slv_resp.ready}};
            m_last    = gnt_oh_q & {NUM_MASTERS{slv_resp.last}};
        end
    end

endmodule

// File: tb/tb_cbus_arbiter.sv
// Bench for cbus_arbiter: a BRAM-wrapper model (delay 2) on the slave side,
// directed scenarios plus randomized traffic checked against a transaction
// level model (round-robin pick over pending masters, word-addressed memory).
module tb_cbus_arbiter;
    localparam int N     = 2;
    localparam int DELAY = 2;

    typedef struct {
        logic [63:0] addr;
        logic [1:0]  burst;
        logic [7:0]  len;
        logic [7:0]  strb;
        logic [63:0] dbase;
        int          start;
    } txn_t;

    logic              clk, reset;
    logic [N-1:0]      m_valid;
    logic [N-1:0][63:0] m_addr, m_wdata;
    logic [N-1:0][7:0] m_wstrobe, m_len;
    logic [N-1:0][1:0] m_burst;
    logic [63:0]       m_rdata;
    logic [N-1:0]      m_ready, m_last;
    logic              s_valid, s_ready, s_last;
    logic [63:0]       s_addr, s_wdata, s_rdata;
    logic [7:0]        s_wstrobe, s_len;
    logic [1:0]        s_burst;

    int   total, bad, rr;
    txn_t txq [N][$];
    int   glog [$];
    logic [63:0] ref_mem [0:255];

    cbus_arbiter #(.NUM_MASTERS(N)) dut (
        .clk(clk), .reset(reset),
        .m_valid(m_valid), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrobe(m_wstrobe),
        .m_burst(m_burst), .m_len(m_len), .m_rdata(m_rdata), .m_ready(m_ready), .m_last(m_last),
        .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrobe(s_wstrobe),
        .s_burst(s_burst), .s_len(s_len), .s_rdata(s_rdata), .s_ready(s_ready), .s_last(s_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] init_word(int k);
        return {32'hC0DE_0000 | 32'(k), 32'(k * 7 + 3)};
    endfunction

    function automatic logic [63:0] merge(logic [63:0] old, logic [63:0] d, logic [7:0] s);
        logic [63:0] r;
        r = old;
        for (int b = 0; b < 8; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    function automatic int word_of(txn_t t, int b);
        int base;
        base = int'(t.addr[10:3]);
        if (t.burst == 2'b01) return (base + b) % 256;
        return base;
    endfunction

    function automatic int pick(logic [N-1:0] pend, int p);
        for (int k = 0; k < N; k++) if (pend[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    // ---------------- BRAM wrapper model ----------------
    logic [63:0] mem [0:255];
    bit          mem_inited = 1'b0;
    int          dcnt, sbeat;
    logic [7:0]  widx;

    always_comb widx = (s_burst == 2'b01) ? (s_addr[10:3] + 8'(sbeat)) : s_addr[10:3];
    assign s_ready = s_valid && (dcnt == DELAY);
    assign s_last  = s_ready && (sbeat == int'(s_len));
    assign s_rdata = s_ready ? mem[widx] : 64'h0;

    always @(posedge clk) begin
        if (!mem_inited) begin
            for (int k = 0; k < 256; k++) mem[k] <= init_word(k);
            mem_inited <= 1'b1;
            dcnt  <= 0;
            sbeat <= 0;
        end else if (!s_valid) begin
            dcnt  <= 0;
            sbeat <= 0;
        end else if (s_ready) begin
            if (|s_wstrobe) mem[widx] <= merge(mem[widx], s_wdata, s_wstrobe);
            dcnt  <= 0;
            sbeat <= s_last ? 0 : sbeat + 1;
        end else begin
            dcnt <= dcnt + 1;
        end
    end

    // ---------------- transaction engine ----------------
    task automatic run_traffic(input int budget);
        txn_t cur [N];
        int   beat [N];
        bit   act [N], adv [N], fin [N];
        logic [N-1:0] pend_prev, pend_rel, actv;
        int   cg, lowc, cyc, exp_g, w;
        bit   prev_sv, had_grant, busy;
        cg = -1; lowc = 0; cyc = 0; prev_sv = 0; had_grant = 0;
        pend_prev = '0; pend_rel = '0; actv = '0;
        for (int i = 0; i < N; i++) begin act[i] = 0; beat[i] = 0; end
        @(posedge clk); #1;
        forever begin
            for (int i = 0; i < N; i++)
                if (!act[i] && txq[i].size() > 0 && txq[i][0].start <= cyc) begin
                    cur[i] = txq[i].pop_front();
                    act[i] = 1; beat[i] = 0;
                    m_addr[i] = cur[i].addr; m_wdata[i] = cur[i].dbase;
                    m_wstrobe[i] = cur[i].strb; m_burst[i] = cur[i].burst;
                    m_len[i] = cur[i].len; m_valid[i] = 1'b1;
                end
            busy = 0;
            for (int i = 0; i < N; i++) if (act[i] || txq[i].size() > 0) busy = 1;
            if (!busy) break;
            if (cyc >= budget) begin
                total++; bad++;
                $display("FAIL traffic_timeout cycles=%0d limit=%0d", cyc, budget);
                break;
            end
            @(negedge clk);
            for (int i = 0; i < N; i++) actv[i] = act[i];
            if (s_valid && !prev_sv) begin
                exp_g = pick(pend_prev, rr);
                total++;
                if (exp_g < 0) begin
                    bad++;
                    $display("FAIL grant_pick s_valid rose with no pending master, s_addr=%0h", s_addr);
                end else if (s_addr !== cur[exp_g].addr || s_len !== cur[exp_g].len) begin
                    bad++;
                    $display("FAIL grant_pick got addr=%0h len=%0d exp master %0d addr=%0h len=%0d",
                             s_addr, s_len, exp_g, cur[exp_g].addr, cur[exp_g].len);
                end
                if (had_grant && pend_rel != '0) begin
                    total++;
                    if (lowc != 2) begin
                        bad++;
                        $display("FAIL grant_gap got=%0d exp=2 low cycles", lowc);
                    end
                end
                cg = exp_g;
            end
            for (int i = 0; i < N; i++) begin
                adv[i] = 0; fin[i] = 0;
                if (m_ready[i] || m_last[i]) begin
                    total++;
                    if (i != cg || !m_ready[i]) begin
                        bad++;
                        $display("FAIL beat_steer master=%0d ready=%b last=%b granted=%0d",
                                 i, m_ready[i], m_last[i], cg);
                    end else begin
                        w = word_of(cur[i], beat[i]);
                        if (cur[i].strb == 8'h0) begin
                            total++;
                            if (m_rdata !== ref_mem[w]) begin
                                bad++;
                                $display("FAIL rdata master=%0d beat=%0d got=%0h exp=%0h",
                                         i, beat[i], m_rdata, ref_mem[w]);
                            end
                        end else begin
                            ref_mem[w] = merge(ref_mem[w], cur[i].dbase + 64'(beat[i]), cur[i].strb);
                        end
                        total++;
                        if (m_last[i] !== (beat[i] == int'(cur[i].len))) begin
                            bad++;
                            $display("FAIL last_flag master=%0d beat=%0d got=%b exp=%b",
                                     i, beat[i], m_last[i], beat[i] == int'(cur[i].len));
                        end
                        adv[i] = 1;
                        if (m_last[i]) begin
                            fin[i] = 1; glog.push_back(i);
                            rr = (i + 1) % N; cg = -1; had_grant = 1;
                        end
                    end
                end
            end
            if (s_valid) lowc = 0;
            else begin
                lowc++;
                if (lowc == 1) pend_rel = actv;
            end
            pend_prev = actv;
            prev_sv   = s_valid;
            @(posedge clk); #1; cyc++;
            for (int i = 0; i < N; i++)
                if (adv[i]) begin
                    if (fin[i]) begin act[i] = 0; m_valid[i] = 1'b0; end
                    else begin beat[i]++; m_wdata[i] = cur[i].dbase + 64'(beat[i]); end
                end
        end
        m_valid = '0;
    endtask

    task automatic finish_burst(input int i);
        bit done;
        done = 0;
        for (int c = 0; c < 40; c++) begin
            if (m_ready[i] && m_last[i]) begin done = 1; break; end
            @(negedge clk);
        end
        total++;
        if (!done) begin bad++; $display("FAIL burst_done master=%0d got=no last exp=last", i); end
        @(negedge clk);
        m_valid[i] = 1'b0;
        rr = (i + 1) % N;
    endtask

    function automatic txn_t mk(logic [63:0] a, logic [1:0] b, logic [7:0] l,
                                logic [7:0] s, logic [63:0] d, int st);
        txn_t t;
        t.addr = a; t.burst = b; t.len = l; t.strb = s; t.dbase = d; t.start = st;
        return t;
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset;
        reset = 1'b1;
        m_valid = '1;
        m_addr[0] = 64'h1234; m_len[0] = 8'd3;
        repeat (3) @(negedge clk);
        total++; if (s_valid !== 1'b0) begin bad++; $display("FAIL reset_s_valid got=%b exp=0", s_valid); end
        total++; if (m_ready !== '0) begin bad++; $display("FAIL reset_m_ready got=%b exp=0", m_ready); end
        total++; if (m_last !== '0) begin bad++; $display("FAIL reset_m_last got=%b exp=0", m_last); end
        total++;
        if ({s_addr, s_wdata, s_wstrobe, s_burst, s_len} !== '0) begin
            bad++; $display("FAIL reset_s_fields got addr=%0h len=%0d exp=0", s_addr, s_len);
        end
        m_valid = '0;
        reset = 1'b0;
        rr = 0;
        @(negedge clk);
        total++; if (s_valid !== 1'b0) begin bad++; $display("FAIL idle_s_valid got=%b exp=0", s_valid); end
    endtask

    task automatic test_single_read;
        int  nr0, nr1;
        bit  seen;
        nr0 = 0; nr1 = 0; seen = 0;
        m_addr[0] = 64'h100; m_burst[0] = 2'b00; m_len[0] = 8'd0;
        m_wstrobe[0] = 8'h0; m_valid[0] = 1'b1;
        @(negedge clk);
        total++;
        if (s_valid !== 1'b1 || s_addr !== 64'h100) begin
            bad++; $display("FAIL single_latency got valid=%b addr=%0h exp valid=1 addr=100", s_valid, s_addr);
        end
        for (int c = 0; c < 20 && !seen; c++) begin
            if (c > 0) @(negedge clk);
            if (m_ready[1]) nr1++;
            if (m_ready[0]) begin
                nr0++;
                total++;
                if (m_rdata !== ref_mem[32]) begin
                    bad++; $display("FAIL single_rdata got=%0h exp=%0h", m_rdata, ref_mem[32]);
                end
            end
            if (m_last[0]) seen = 1;
        end
        @(negedge clk);
        m_valid[0] = 1'b0;
        rr = 1;
        total++; if (s_valid !== 1'b0) begin bad++; $display("FAIL single_gap1 got=%b exp=0", s_valid); end
        @(negedge clk);
        total++; if (s_valid !== 1'b0) begin bad++; $display("FAIL single_gap2 got=%b exp=0", s_valid); end
        total++; if (nr0 != 1 || !seen) begin bad++; $display("FAIL single_beats got=%0d exp=1", nr0); end
        total++; if (nr1 != 0) begin bad++; $display("FAIL single_other_ready got=%0d exp=0", nr1); end
    endtask

    task automatic test_alternate;
        reset = 1'b1; @(negedge clk); reset = 1'b0; rr = 0;
        glog.delete();
        for (int k = 0; k < 2; k++) begin
            txq[0].push_back(mk(64'h300 + 64'(k * 8), 2'b00, 8'(k), 8'h0, 64'h0, 0));
            txq[1].push_back(mk(64'h400 + 64'(k * 8), 2'b01, 8'(k + 1), 8'h0, 64'h0, 0));
        end
        run_traffic(500);
        total++;
        if (glog.size() != 4) begin
            bad++; $display("FAIL alt_count got=%0d exp=4", glog.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                total++;
                if (glog[k] != k % 2) begin
                    bad++; $display("FAIL alt_order idx=%0d got=%0d exp=%0d", k, glog[k], k % 2);
                end
            end
        end
    endtask

    task automatic test_write_read;
        txq[1].push_back(mk(64'h100, 2'b01, 8'd3, 8'hFF, 64'hA0, 0));
        run_traffic(300);
        for (int k = 0; k < 4; k++) begin
            total++;
            if (mem[32 + k] !== 64'hA0 + 64'(k)) begin
                bad++; $display("FAIL wr_mem word=%0h got=%0h exp=%0h", 32 + k, mem[32 + k], 64'hA0 + 64'(k));
            end
        end
        txq[0].push_back(mk(64'h100, 2'b01, 8'd3, 8'h0, 64'h0, 0));
        run_traffic(300);
    endtask

    task automatic test_hold_during_burst;
        glog.delete();
        txq[1].push_back(mk(64'h800, 2'b01, 8'd7, 8'h0, 64'h0, 0));
        txq[0].push_back(mk(64'h40, 2'b00, 8'd0, 8'h0, 64'h0, 3));
        run_traffic(300);
        total++;
        if (glog.size() != 2 || glog[0] != 1 || glog[1] != 0) begin
            bad++; $display("FAIL hold_order got size=%0d exp order 1,0", glog.size());
        end
    endtask

    task automatic test_reset_mid_burst;
        int nr0, nr1;
        bit up;
        nr0 = 0; nr1 = 0; up = 0;
        @(negedge clk);
        m_addr[0] = 64'h200; m_burst[0] = 2'b01; m_len[0] = 8'd7;
        m_wstrobe[0] = 8'h0; m_valid[0] = 1'b1;
        for (int c = 0; c < 6 && !up; c++) begin
            @(negedge clk);
            if (s_valid) up = 1;
        end
        total++; if (!up) begin bad++; $display("FAIL rst_mid_grant got=0 exp=1"); end
        m_addr[1] = 64'h480; m_burst[1] = 2'b00; m_len[1] = 8'd0;
        m_wstrobe[1] = 8'h0; m_valid[1] = 1'b1;
        for (int c = 0; c < 40 && nr0 < 3; c++) begin
            if (c > 0) @(negedge clk);
            if (m_ready[0]) nr0++;
            if (m_ready[1]) nr1++;
        end
        total++; if (nr0 != 3 || nr1 != 0) begin bad++; $display("FAIL rst_mid_beats got=%0d/%0d exp=3/0", nr0, nr1); end
        reset = 1'b1;
        #1;
        total++; if (s_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_s_valid got=%b exp=0", s_valid); end
        total++;
        if (m_ready !== '0 || m_last !== '0) begin
            bad++; $display("FAIL rst_mid_handshake got ready=%b last=%b exp=0", m_ready, m_last);
        end
        m_valid[0] = 1'b0;
        @(negedge clk);
        reset = 1'b0; rr = 0;
        @(negedge clk);
        total++;
        if (s_valid !== 1'b1 || s_addr !== 64'h480) begin
            bad++; $display("FAIL rst_mid_next got valid=%b addr=%0h exp valid=1 addr=480", s_valid, s_addr);
        end
        finish_burst(1);
    endtask

    task automatic test_abort;
        @(negedge clk);
        m_addr[0] = 64'h300; m_burst[0] = 2'b01; m_len[0] = 8'd3; m_wstrobe[0] = 8'h0;
        m_addr[1] = 64'h400; m_burst[1] = 2'b00; m_len[1] = 8'd0; m_wstrobe[1] = 8'h0;
        m_valid = '1;
        @(negedge clk);
        total++;
        if (s_valid !== 1'b1 || s_addr !== 64'h300) begin
            bad++; $display("FAIL abort_first got valid=%b addr=%0h exp valid=1 addr=300", s_valid, s_addr);
        end
        m_valid[0] = 1'b0;
        @(negedge clk);
        total++; if (s_valid !== 1'b0) begin bad++; $display("FAIL abort_idle got=%b exp=0", s_valid); end
        @(negedge clk);
        total++;
        if (s_valid !== 1'b1 || s_addr !== 64'h400) begin
            bad++; $display("FAIL abort_next got valid=%b addr=%0h exp valid=1 addr=400", s_valid, s_addr);
        end
        finish_burst(1);
    endtask

    task automatic test_random;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < N; i++)
                for (int k = 0; k < 3; k++)
                    txq[i].push_back(mk(64'($urandom_range(0, 255) * 8), 2'($urandom_range(0, 3)),
                                        8'($urandom_range(0, 7)),
                                        ($urandom_range(0, 1) != 0) ? 8'($urandom_range(1, 255)) : 8'h0,
                                        {$urandom, $urandom}, int'($urandom_range(0, 5))));
            run_traffic(3000);
        end
    endtask

    initial begin
        total = 0; bad = 0; rr = 0;
        for (int k = 0; k < 256; k++) ref_mem[k] = init_word(k);
        reset = 1'b1;
        m_valid = '0; m_addr = '0; m_wdata = '0; m_wstrobe = '0; m_burst = '0; m_len = '0;
        test_reset;
        test_single_read;
        test_alternate;
        test_write_read;
        test_hold_during_burst;
        test_reset_mid_burst;
        test_abort;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
